// File: rtl/cs_mseq_if.sv
// cs_mseq_if: microsequencer bus to the control store and incrementer.
// master = sequencer side; slave = control-store/datapath side.
interface cs_mseq_if #(
  parameter int AW = 11
);
  logic [AW-1:0] CS_MSEQ_CSAI_ADDR;
  logic [2:0]    CS_MSEQ_BRANCH_TYPE;
  logic [AW-1:0] CS_MSEQ_BRANCH_ADDR;
  logic [1:0]    CS_MSEQ_COND_SEL;
  logic [3:0]    CS_MSEQ_FLAGS;
  logic [AW-1:0] CS_MSEQ_DISPATCH_ADDR;
  logic          CS_MSEQ_STALL;
  logic [AW-1:0] CS_MSEQ_UADDR;
  logic          CS_MSEQ_ACK;
  logic          CS_MSEQ_STACK_OVF;
  logic          CS_MSEQ_STACK_UNF;

  modport master (
    input  CS_MSEQ_CSAI_ADDR,
    input  CS_MSEQ_BRANCH_TYPE,
    input  CS_MSEQ_BRANCH_ADDR,
    input  CS_MSEQ_COND_SEL,
    input  CS_MSEQ_FLAGS,
    input  CS_MSEQ_DISPATCH_ADDR,
    input  CS_MSEQ_STALL,
    output CS_MSEQ_UADDR,
    output CS_MSEQ_ACK,
    output CS_MSEQ_STACK_OVF,
    output CS_MSEQ_STACK_UNF
  );

  modport slave (
    output CS_MSEQ_CSAI_ADDR,
    output CS_MSEQ_BRANCH_TYPE,
    output CS_MSEQ_BRANCH_ADDR,
    output CS_MSEQ_COND_SEL,
    output CS_MSEQ_FLAGS,
    output CS_MSEQ_DISPATCH_ADDR,
    output CS_MSEQ_STALL,
    input  CS_MSEQ_UADDR,
    input  CS_MSEQ_ACK,
    input  CS_MSEQ_STACK_OVF,
    input  CS_MSEQ_STACK_UNF
  );
endinterface

// File: rtl/cs_mseq.sv
// cs_mseq: control-store microsequencer (ISSUE/WAIT/DECIDE per microcycle).
// Define CS_MSEQ_STACK_EN to build the return stack and OVF/UNF flags.
module cs_mseq #(
  parameter int CS_MSEQ_LENGTH_ADDR = 11,
  parameter int CS_MSEQ_CS_LATENCY  = 1,
  parameter int CS_MSEQ_STACK_DEPTH = 4
) (
  input  logic      CS_MSEQ_CLOCK_50,
  input  logic      CS_MSEQ_RESET,
  cs_mseq_if.master bus
);
  localparam int AW = CS_MSEQ_LENGTH_ADDR;
  localparam logic [2:0] LAT = 3'(CS_MSEQ_CS_LATENCY);

  localparam logic [2:0] BT_NEXT = 3'd0;
  localparam logic [2:0] BT_JMP  = 3'd1;
  localparam logic [2:0] BT_JIF  = 3'd2;
  localparam logic [2:0] BT_JIFN = 3'd3;
  localparam logic [2:0] BT_DISP = 3'd4;
  localparam logic [2:0] BT_CALL = 3'd5;
  localparam logic [2:0] BT_RET  = 3'd6;
  localparam logic [2:0] BT_HOLD = 3'd7;

  if (CS_MSEQ_CS_LATENCY < 1 || CS_MSEQ_CS_LATENCY > 7 ||
      CS_MSEQ_STACK_DEPTH < 2 || CS_MSEQ_STACK_DEPTH > 8) begin : g_cfg_err
    $error("cs_mseq: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DECIDE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d, cnt_sat;
  logic [AW-1:0] upc_q, upc_d;
  logic          ack_q, ack_d;
  logic          cond;
  logic [AW-1:0] csai, bra;

  assign csai    = bus.CS_MSEQ_CSAI_ADDR;
  assign bra     = bus.CS_MSEQ_BRANCH_ADDR;
  assign cond    = bus.CS_MSEQ_FLAGS[bus.CS_MSEQ_COND_SEL];
  assign cnt_sat = (cnt_q == LAT) ? cnt_q : cnt_q + 3'd1;

`ifdef CS_MSEQ_STACK_EN
  localparam int DEPTH = CS_MSEQ_STACK_DEPTH;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  logic [AW-1:0] stk_q [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [PW-1:0] wr_idx, top_idx;
  logic          push, full, empty;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  assign wr_idx  = sp_q[PW-1:0];
  assign top_idx = PW'(sp_q - SW'(1));
  assign full    = (sp_q == SW'(DEPTH));
  assign empty   = (sp_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upc_d   = upc_q;
    ack_d   = 1'b0;
`ifdef CS_MSEQ_STACK_EN
    sp_d  = sp_q;
    push  = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif
    unique case (state_q)
      S_ISSUE: begin
        ack_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_sat;
        if (cnt_sat == LAT && !bus.CS_MSEQ_STALL)
          state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_ISSUE;
        unique case (bus.CS_MSEQ_BRANCH_TYPE)
          BT_NEXT: upc_d = csai;
          BT_JMP:  upc_d = bra;
          BT_JIF:  upc_d = cond ? bra : csai;
          BT_JIFN: upc_d = cond ? csai : bra;
          BT_DISP: upc_d = bus.CS_MSEQ_DISPATCH_ADDR;
`ifdef CS_MSEQ_STACK_EN
          BT_CALL: begin
            upc_d = bra;
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SW'(1);
            end
          end
          BT_RET: begin
            if (empty) begin
              upc_d = '0;
              unf_d = 1'b1;
            end else begin
              upc_d = stk_q[top_idx];
              sp_d  = sp_q - SW'(1);
            end
          end
`else
          BT_CALL: upc_d = bra;
          BT_RET:  upc_d = csai;
`endif
          BT_HOLD: upc_d = upc_q;
        endcase
      end
      default: state_d = S_ISSUE;
    endcase
  end

  always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET) begin
    if (!CS_MSEQ_RESET) begin
      state_q <= S_ISSUE;
      cnt_q   <= '0;
      upc_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upc_q   <= upc_d;
      ack_q   <= ack_d;
    end
  end

`ifdef CS_MSEQ_STACK_EN
  always_ff @(posedge CS_MSEQ_CLOCK_50 or negedge CS_MSEQ_RESET) begin
    if (!CS_MSEQ_RESET) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entries need no reset: sp_q alone decides what is valid.
  always_ff @(posedge CS_MSEQ_CLOCK_50) begin
    if (push)
      stk_q[wr_idx] <= csai;
  end

  assign bus.CS_MSEQ_STACK_OVF = ovf_q;
  assign bus.CS_MSEQ_STACK_UNF = unf_q;
`else
  assign bus.CS_MSEQ_STACK_OVF = 1'b0;
  assign bus.CS_MSEQ_STACK_UNF = 1'b0;
`endif

  assign bus.CS_MSEQ_UADDR = upc_q;
  assign bus.CS_MSEQ_ACK   = ack_q;
endmodule

// File: tb/tb_cs_mseq.sv
// tb_cs_mseq: scoreboard bench for cs_mseq with a modelled incrementer.
// Expected micro-addresses are queued at drive time and popped on ACK.
module tb_cs_mseq;
  localparam int DEPTH = 4;
  localparam logic [2:0] NEXT = 3'd0;
  localparam logic [2:0] JMP  = 3'd1;
  localparam logic [2:0] JIF  = 3'd2;
  localparam logic [2:0] JIFN = 3'd3;
  localparam logic [2:0] DISP = 3'd4;
  localparam logic [2:0] CALL = 3'd5;
  localparam logic [2:0] RET  = 3'd6;
  localparam logic [2:0] HOLD = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cs_mseq_if bus ();

  cs_mseq dut (
    .CS_MSEQ_CLOCK_50(clk),
    .CS_MSEQ_RESET   (rst_n),
    .bus             (bus)
  );

  assign bus.CS_MSEQ_CSAI_ADDR = bus.CS_MSEQ_UADDR + 11'd1;

  int n_chk = 0;
  int n_pass = 0;
  int last_cyc;
  logic [10:0] exp_q[$];
  logic [10:0] mstk[$];
  logic [10:0] mu;
  logic movf, munf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic take_ack(input string tag);
    logic [10:0] e;
    last_cyc = 0;
    do begin
      @(negedge clk);
      last_cyc++;
    end while (bus.CS_MSEQ_ACK !== 1'b1 && last_cyc < 100);
    if (bus.CS_MSEQ_ACK !== 1'b1)
      chk({tag, "_timeout"}, 32'(bus.CS_MSEQ_ACK), 32'd1);
    e = exp_q.pop_front();
    chk(tag, 32'(bus.CS_MSEQ_UADDR), 32'(e));
    chk({tag, "_ovf"}, 32'(bus.CS_MSEQ_STACK_OVF), 32'(movf));
    chk({tag, "_unf"}, 32'(bus.CS_MSEQ_STACK_UNF), 32'(munf));
  endtask

  task automatic step(input string tag, input logic [2:0] bt,
                      input logic [10:0] ba, input logic [10:0] da,
                      input logic [3:0] fl, input logic [1:0] cs,
                      input int st);
    logic [10:0] nx, inc;
    logic c;
    bus.CS_MSEQ_BRANCH_TYPE   = bt;
    bus.CS_MSEQ_BRANCH_ADDR   = ba;
    bus.CS_MSEQ_DISPATCH_ADDR = da;
    bus.CS_MSEQ_FLAGS         = fl;
    bus.CS_MSEQ_COND_SEL      = cs;
    inc = mu + 11'd1;
    c = fl[cs];
    nx = inc;
    case (bt)
      NEXT: nx = inc;
      JMP:  nx = ba;
      JIF:  nx = c ? ba : inc;
      JIFN: nx = c ? inc : ba;
      DISP: nx = da;
`ifdef CS_MSEQ_STACK_EN
      CALL: begin
        nx = ba;
        if (mstk.size() < DEPTH) mstk.push_back(inc);
        else movf = 1'b1;
      end
      RET: begin
        if (mstk.size() > 0) nx = mstk.pop_back();
        else begin
          nx = 11'd0;
          munf = 1'b1;
        end
      end
`else
      CALL: nx = ba;
      RET:  nx = inc;
`endif
      HOLD: nx = mu;
      default: nx = inc;
    endcase
    mu = nx;
    exp_q.push_back(nx);
    if (st > 0) begin
      bus.CS_MSEQ_STALL = 1'b1;
      for (int i = 0; i < st; i++) begin
        @(negedge clk);
        chk({tag, "_stall_ack"}, 32'(bus.CS_MSEQ_ACK), 32'd0);
      end
      bus.CS_MSEQ_STALL = 1'b0;
    end
    take_ack(tag);
    chk({tag, "_per"}, 32'(last_cyc), (st > 0) ? 32'd3 : 32'd3);
  endtask

  task automatic boot(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    mu = 11'd0;
    mstk.delete();
    movf = 1'b0;
    munf = 1'b0;
    exp_q.push_back(11'd0);
    take_ack(tag);
    chk({tag, "_lat"}, 32'(last_cyc), 32'd1);
  endtask

  initial begin
    bus.CS_MSEQ_BRANCH_TYPE   = NEXT;
    bus.CS_MSEQ_BRANCH_ADDR   = '0;
    bus.CS_MSEQ_DISPATCH_ADDR = '0;
    bus.CS_MSEQ_FLAGS         = '0;
    bus.CS_MSEQ_COND_SEL      = '0;
    bus.CS_MSEQ_STALL         = 1'b0;
    #12;
    chk("rst_uaddr", 32'(bus.CS_MSEQ_UADDR), 32'd0);
    chk("rst_ack", 32'(bus.CS_MSEQ_ACK), 32'd0);
    chk("rst_ovf", 32'(bus.CS_MSEQ_STACK_OVF), 32'd0);
    chk("rst_unf", 32'(bus.CS_MSEQ_STACK_UNF), 32'd0);
    boot("boot");

    step("seq1", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("seq2", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("seq3", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);

    step("to010a", JMP,  11'h010, 11'h000, 4'h0,    2'd0, 0);
    step("jif_t",  JIF,  11'h200, 11'h000, 4'b0001, 2'd0, 0);
    step("to010b", JMP,  11'h010, 11'h000, 4'h0,    2'd0, 0);
    step("jifn_n", JIFN, 11'h200, 11'h000, 4'b0001, 2'd0, 0);
    step("jif_n",  JIF,  11'h200, 11'h000, 4'b0001, 2'd1, 0);
    step("jifn_t", JIFN, 11'h2AA, 11'h000, 4'b1011, 2'd2, 0);
    step("hold",   HOLD, 11'h555, 11'h000, 4'hF,    2'd0, 0);

    step("to7ff", JMP,  11'h7FF, 11'h000, 4'h0, 2'd0, 0);
    step("wrap",  NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);

    step("to020", JMP,  11'h020, 11'h000, 4'h0, 2'd0, 0);
    step("call1", CALL, 11'h300, 11'h000, 4'h0, 2'd0, 0);
    step("inner", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("ret1",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);

    step("nc1",  CALL, 11'h100, 11'h000, 4'h0, 2'd0, 0);
    step("nc2",  CALL, 11'h110, 11'h000, 4'h0, 2'd0, 0);
    step("nc3",  CALL, 11'h120, 11'h000, 4'h0, 2'd0, 0);
    step("nc4",  CALL, 11'h130, 11'h000, 4'h0, 2'd0, 0);
    step("nc5",  CALL, 11'h140, 11'h000, 4'h0, 2'd0, 0);
    step("nr4",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("nr3",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("nr2",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("nr1",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("nr0",  RET,  11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("keep1", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);
    step("keep2", JMP,  11'h040, 11'h000, 4'h0, 2'd0, 0);

    step("stall_disp", DISP, 11'h000, 11'h155, 4'h0, 2'd0, 5);
    step("post",       NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_uaddr", 32'(bus.CS_MSEQ_UADDR), 32'd0);
    chk("arst_ack", 32'(bus.CS_MSEQ_ACK), 32'd0);
    chk("arst_ovf", 32'(bus.CS_MSEQ_STACK_OVF), 32'd0);
    chk("arst_unf", 32'(bus.CS_MSEQ_STACK_UNF), 32'd0);
    boot("reboot");
    step("after", NEXT, 11'h000, 11'h000, 4'h0, 2'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
